// File: rtl/floo_mcast_seq_pkg.sv
// floo_mcast_seq_pkg: shared state type and popcount helper for the multicast sequencer
package floo_mcast_seq_pkg;
  typedef enum logic {IDLE, ISSUE} mcast_seq_state_e;
  function automatic int unsigned popcnt(input logic [63:0] v);
    popcnt = 0;
    for (int i = 0; i < 64; i++) popcnt += {31'b0, v[i]};
  endfunction
endpackage

// File: rtl/floo_mcast_seq_lzc.sv
// floo_mcast_seq_lzc: trailing-zero counter, gives index of lowest set bit plus empty flag
module floo_mcast_seq_lzc #(
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(Width)
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);
  // scan from the top down so the lowest set bit wins
  always_comb begin
    cnt_o = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) if (in_i[i]) cnt_o = CntW'(i);
  end
  assign empty_o = ~|in_i;
endmodule

// File: rtl/floo_mcast_seq.sv
// floo_mcast_seq: replicates one multicast request into serial unicast copies, lowest index first
module floo_mcast_seq
  import floo_mcast_seq_pkg::*;
#(
  parameter int unsigned NumDst = 8,
  parameter type id_t = logic,
  parameter type payload_t = logic,
  localparam int unsigned CntWidth = $clog2(NumDst) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  payload_t                 in_payload_i,
  input  logic [NumDst-1:0]        in_select_i,
  input  id_t [NumDst-1:0]         id_map_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output payload_t                 out_payload_o,
  output id_t                      out_dst_id_o,
  output logic [CntWidth-1:0]      out_seq_o,
  output logic                     out_last_o,
  output logic [CntWidth-1:0]      rep_cnt_o,
  output logic                     busy_o,
  output logic                     empty_err_o
);
  localparam int unsigned IdxWidth = $clog2(NumDst);
  localparam logic [NumDst-1:0] One = 1;
  mcast_seq_state_e state_q, state_d;
  logic [NumDst-1:0] mask_q;
  payload_t payload_q;
  logic [CntWidth-1:0] seq_q, rep_cnt_q;
  logic empty_err_q, mask_empty;
  logic [IdxWidth-1:0] idx;
  logic accept, out_hs;
  floo_mcast_seq_lzc #(.Width(NumDst)) i_lzc (
    .in_i    (mask_q),
    .cnt_o   (idx),
    .empty_o (mask_empty)
  );
  assign in_ready_o    = (state_q == IDLE);
  assign out_valid_o   = (state_q == ISSUE);
  assign busy_o        = (state_q != IDLE);
  assign accept        = in_valid_i && in_ready_o;
  assign out_hs        = out_valid_o && out_ready_i;
  assign out_payload_o = payload_q;
  assign out_dst_id_o  = id_map_i[idx];
  assign out_last_o    = !mask_empty && ((mask_q & (mask_q - One)) == '0);
  assign out_seq_o     = seq_q;
  assign rep_cnt_o     = rep_cnt_q;
  assign empty_err_o   = empty_err_q;
  // next state: start on a non-empty accept, return after the last copy handshakes
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? ((accept && |in_select_i) ? ISSUE : IDLE)
                                : ((out_hs && out_last_o) ? IDLE : ISSUE);
  end
  // state register and datapath; each handshake drops the lowest pending bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      payload_q   <= '0;
      seq_q       <= '0;
      rep_cnt_q   <= '0;
      empty_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      empty_err_q <= accept && ~|in_select_i;
      if (accept && |in_select_i) begin
        payload_q <= in_payload_i;
        mask_q    <= in_select_i;
        seq_q     <= '0;
        rep_cnt_q <= CntWidth'(popcnt(64'(in_select_i)));
      end else if (out_hs) begin
        mask_q <= mask_q & (mask_q - One);
        seq_q  <= out_last_o ? '0 : seq_q + CntWidth'(1);
      end
    end
  end
  a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o && !out_ready_i |=> $stable(out_payload_o) && $stable(out_dst_id_o) && $stable(out_last_o));
  a_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(in_ready_o && out_valid_o));
endmodule

// File: tb/tb_floo_mcast_seq.sv
// tb_floo_mcast_seq: directed and random checks of the multicast sequencer against a copy-list model
module tb_floo_mcast_seq;
  localparam int N = 8;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_last, busy, empty_err;
  logic [15:0] in_payload = '0, out_payload;
  logic [N-1:0] in_select = '0;
  logic [N-1:0][7:0] id_map;
  logic [7:0] out_dst_id;
  logic [3:0] out_seq, rep_cnt;
  int n_chk = 0, n_fail = 0;
  bit pat [5] = '{1, 0, 0, 1, 1};
  typedef struct {logic [7:0] id; logic [3:0] seq; logic last;} copy_t;
  copy_t exp_q[$];

  always #5 clk = ~clk;

  floo_mcast_seq #(.NumDst(N), .id_t(logic [7:0]), .payload_t(logic [15:0])) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_payload_i(in_payload), .in_select_i(in_select), .id_map_i(id_map),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_payload_o(out_payload),
    .out_dst_id_o(out_dst_id), .out_seq_o(out_seq), .out_last_o(out_last),
    .rep_cnt_o(rep_cnt), .busy_o(busy), .empty_err_o(empty_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: random ready, 2: fixed stall pattern
  task automatic issue(input logic [7:0] mask, input logic [15:0] pl, input int mode,
                       input int abort_after, input logic hold_v, input logic [7:0] hold_mask);
    int hs = 0, cyc = 0, pi = 0, n, s = 0;
    bit r;
    n = $countones(mask);
    exp_q.delete();
    for (int i = 0; i < N; i++)
      if (mask[i]) begin
        exp_q.push_back('{id_map[i], 4'(s), s == n - 1});
        s++;
      end
    chk("idle_ready", 32'(in_ready), 1);
    chk("idle_valid", 32'(out_valid), 0);
    in_valid = 1; in_select = mask; in_payload = pl; out_ready = 0;
    tick();
    in_valid = hold_v; in_select = hold_mask; in_payload = ~pl;
    if (n == 0) begin
      chk("empty_err", 32'(empty_err), 1);
      chk("empty_valid", 32'(out_valid), 0);
      chk("empty_busy", 32'(busy), 0);
      in_valid = 0;
      tick();
      chk("empty_err_clr", 32'(empty_err), 0);
      chk("empty_valid2", 32'(out_valid), 0);
      return;
    end
    while (exp_q.size() > 0) begin
      if (cyc++ > 200) begin
        chk("timeout_left", 32'(exp_q.size()), 0);
        return;
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (pi < 5 ? pat[pi] : 1'b1);
      pi++;
      chk("valid", 32'(out_valid), 1);
      chk("in_ready_busy", 32'(in_ready), 0);
      chk("busy", 32'(busy), 1);
      chk("payload", 32'(out_payload), 32'(pl));
      chk("dst_id", 32'(out_dst_id), 32'(exp_q[0].id));
      chk("seq", 32'(out_seq), 32'(exp_q[0].seq));
      chk("last", 32'(out_last), 32'(exp_q[0].last));
      chk("rep_cnt", 32'(rep_cnt), 32'(n));
      if (hs == abort_after) begin
        out_ready = 0; rst = 1;
        tick();
        rst = 0; in_valid = 0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_rep_cnt", 32'(rep_cnt), 0);
        tick();
        chk("rst_valid2", 32'(out_valid), 0);
        exp_q.delete();
        return;
      end
      out_ready = r;
      tick();
      if (r) begin
        void'(exp_q.pop_front());
        hs++;
      end
    end
    out_ready = 0;
    chk("hs_count", 32'(hs), 32'(n));
    chk("done_valid", 32'(out_valid), 0);
    chk("done_ready", 32'(in_ready), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_rep_cnt", 32'(rep_cnt), 32'(n));
    chk("done_seq", 32'(out_seq), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) id_map[i] = 8'(i + 16);
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_empty_err", 32'(empty_err), 0);
    chk("rst_rep_cnt", 32'(rep_cnt), 0);
    chk("rst_seq", 32'(out_seq), 0);
    chk("rst_payload", 32'(out_payload), 0);
    rst = 0;
    tick();
    issue(8'hA4, 16'h1234, 0, -1, 0, 8'h00);
    issue(8'hA4, 16'h5678, 2, -1, 0, 8'h00);
    issue(8'h00, 16'h0BAD, 0, -1, 0, 8'h00);
    issue(8'hFF, 16'hCAFE, 0, -1, 0, 8'h00);
    issue(8'h01, 16'hBEEF, 0, -1, 0, 8'h00);
    issue(8'h3C, 16'h1111, 0, 2, 0, 8'h00);
    issue(8'h3C, 16'h2222, 0, -1, 0, 8'h00);
    issue(8'h12, 16'h3333, 0, -1, 1, 8'h81);
    issue(8'h81, 16'h4444, 1, -1, 0, 8'h00);
    for (int i = 0; i < N; i++) id_map[i] = 8'($urandom);
    for (int k = 0; k < 30; k++) issue(8'($urandom), 16'($urandom), 1, -1, 0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
